// File: rtl/bus_master_if.sv
// Requester-side shared-bus endpoint: requests ownership, issues one strobed
// word access, waits for the slave (with timeout), then hands the result back.
module bus_master_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req,
  input  logic [29:0] core_addr,
  input  logic        core_rw,
  input  logic [31:0] core_wr_data,
  output logic [31:0] core_rd_data,
  output logic        core_busy,
  output logic        core_done,
  output logic        core_err,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, WAIT} state_t;

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_inc;

  assign cnt_inc   = cnt + TO_W'(1);
  assign core_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bus_req_     <= 1'b1;
      bus_as_      <= 1'b1;
      bus_rw       <= 1'b1;
      bus_addr     <= '0;
      bus_wr_data  <= '0;
      core_rd_data <= '0;
      core_done    <= 1'b0;
      core_err     <= 1'b0;
      cnt          <= '0;
    end else begin
      core_done <= 1'b0;
      core_err  <= 1'b0;
      case (state)
        IDLE: begin
          bus_as_ <= 1'b1;
          if (core_req) begin
            bus_addr    <= core_addr;
            bus_rw      <= core_rw;
            bus_wr_data <= core_wr_data;
            bus_req_    <= 1'b0;
            state       <= REQ;
          end else begin
            bus_req_ <= 1'b1;
          end
        end
        REQ: begin
          // A grant parked on us while IDLE never reaches here; only REQ counts.
          bus_req_ <= 1'b0;
          if (!bus_grnt_) begin
            bus_as_ <= 1'b0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          bus_as_ <= 1'b1;
          cnt     <= '0;
          if (!bus_rdy_) begin
            if (bus_rw) core_rd_data <= bus_rd_data;
            core_done <= 1'b1;
            bus_req_  <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          bus_as_ <= 1'b1;
          cnt     <= cnt_inc;
          // Ready is tested first so a late ready beats a same-cycle timeout.
          if (!bus_rdy_) begin
            if (bus_rw) core_rd_data <= bus_rd_data;
            core_done <= 1'b1;
            bus_req_  <= 1'b1;
            state     <= IDLE;
          end else if (cnt_inc >= LIMIT) begin
            core_err <= 1'b1;
            bus_req_ <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
Requester-side endpoint of the shared-bus arbitration and access handshake.
- Accepts single-word read/write commands from a local core.
- Requests bus ownership with active-low bus_req_ and waits for active-low bus_grnt_.
- Issues one address-strobed access, waits for slave bus_rdy_, returns read data and a completion pulse, then releases the request.
- One instance sits between each bus master (CPU IF/MEM stage, DMA) and the round-robin arbiter plus shared address/data bus.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in ACCESS+WAIT without bus_rdy_ before abort; must be ≥1.
TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous reset, active-high
core_req  input  1  command strobe, active-high, sampled only in IDLE
core_addr  input  30  word address
core_rw  input  1  1 = read, 0 = write
core_wr_data  input  32  write data
core_rd_data  output  32  read data, held until next read completes
core_busy  output  1  high whenever state != IDLE
core_done  output  1  one-cycle pulse on successful completion
core_err  output  1  one-cycle pulse on timeout abort
bus_req_  output  1  bus request, active-low
bus_grnt_  input  1  bus grant, active-low
bus_addr  output  30  bus word address
bus_as_  output  1  address strobe, active-low
bus_rw  output  1  1 = read, 0 = write
bus_wr_data  output  32  bus write data
bus_rd_data  input  32  bus read data
bus_rdy_  input  1  slave ready, active-low

Behaviour:
- Clock/reset: one clock clk; reset is asynchronous, active-high.
- Reset values, applied immediately even mid-transaction: state IDLE; bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0, core_rd_data=0, core_done=0, core_err=0, counter=0.
- All outputs are registered. core_busy decodes the state register only.
- FSM states: IDLE, REQ, ACCESS, WAIT.
- IDLE:
  - If core_req=1, latch core_addr, core_rw and core_wr_data into bus_addr, bus_rw and bus_wr_data; drive bus_req_=0; go to REQ.
  - Otherwise bus_req_=1 and stay in IDLE.
- REQ:
  - bus_req_ is held at 0.
  - If bus_grnt_=0 is sampled, drive bus_as_=0 and go to ACCESS.
  - A grant seen while in IDLE (arbiter parked on this master) is ignored. Only grants sampled in REQ count.
  - Grant wait is unbounded; no timeout applies in REQ.
- ACCESS:
  - bus_as_ is low for exactly this one cycle; the next state always drives bus_as_=1.
  - Clear the counter.
  - If bus_rdy_=0 is sampled, complete (see Completion). Otherwise go to WAIT.
- WAIT:
  - bus_req_=0 and bus_as_=1.
  - Increment the counter each cycle.
  - If bus_rdy_=0, complete.
  - Else if the counter reaches TIMEOUT_CYCLES-1, abort (see Abort).
- Completion:
  - If bus_rw=1, core_rd_data <= bus_rd_data; a write leaves core_rd_data unchanged.
  - core_done=1 for one cycle; bus_req_=1; go to IDLE.
- Abort:
  - core_err=1 for one cycle; core_rd_data unchanged; bus_req_=1; go to IDLE.
- Simultaneous bus_rdy_=0 and timeout in the same cycle: completion wins and core_err stays 0.
- core_req while core_busy=1 is ignored and not queued. core_req in the same cycle as core_done (state is IDLE) is accepted, giving back-to-back transactions.
- bus_req_ is released for at least one cycle between transactions, so the round-robin arbiter can rotate to another master.
- Latency with immediate grant and zero-wait slave:
  - core_req at cycle 0.
  - bus_req_=0 in cycle 1.
  - bus_as_=0 in cycle 2, with bus_rdy_=0 sampled at the end of cycle 2.
  - core_done=1 and data valid in cycle 3.
- Each wait cycle before grant or ready adds exactly one cycle.
- bus_rdy_ and bus_grnt_ are ignored in every state except the ones listed above.

Test Plan:
- Read, immediate grant, zero-wait slave: addr=0x0000_0010, rw=1, bus_rd_data=0xDEADBEEF with bus_rdy_=0 in the ACCESS cycle -> bus_as_ low exactly 1 cycle at cycle 2; core_done at cycle 3; core_rd_data=0xDEADBEEF; bus_req_=1 at cycle 3.
- Write, grant delayed 5 cycles, slave 2 wait cycles: wr_data=0x12345678 -> bus_req_ low 5 cycles before bus_as_; bus_wr_data=0x12345678 stable through WAIT; core_done 3 cycles after bus_as_; core_rd_data unchanged.
- Parked grant: bus_grnt_=0 held while IDLE with no core_req -> bus_as_ stays 1 and core_busy=0; core_req then -> bus_req_ low 1 cycle before bus_as_.
- Timeout: TIMEOUT_CYCLES=4, bus_rdy_ held 1 -> core_err pulses once; no core_done; bus_req_=1 afterwards; core_rd_data unchanged; ready and timeout forced in the same cycle -> core_done only.
- Back-to-back: core_req held high across 3 reads -> bus_req_ high exactly 1 cycle between transactions; 3 core_done pulses; a core_req change mid-transaction does not alter bus_addr.
- Reset asserted in the WAIT state -> bus_req_=1, bus_as_=1, core_busy=0 immediately without a clock edge; after release, a new read completes normally.
